iter_div: RTL and testbench

Iterative 32-bit radix-2 restoring divider that answers the execute stage's division requests for DIV/DIVU. The execute stage acts as initiator: it drives operands, signedness and `start_i`, and stalls the pipeline until `ready_o`. This block is the responder: it computes a 64-bit `{remainder, quotient}` result over 32 iteration cycles. The result is held until the initiator releases `start_i`.

---
 rtl/iter_div_if.sv | 23 ++
 rtl/iter_div.sv | 151 +++++++++++++++
 tb/tb_iter_div.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_div_if.sv
// Request/response bundle between the execute stage and iter_div.
// master = execute stage (initiator), slave = divider (responder).
interface iter_div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i,
    output start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i,
    input  start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/iter_div.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU.
// Optional ITER_DIV_ZERO_CHECK_EN: short-circuit divide-by-zero to 0.
module iter_div (
  input logic       clk,
  input logic       rst,
  iter_div_if.slave bus
);

  typedef enum logic [1:0] {
    FREE, BYZERO, ON, END
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
  logic [63:0] res_d;
  logic        rdy_d;

  logic        accept;
  logic        abort;
  logic        sgn1, sgn2;
  logic [31:0] mag1, mag2;
  logic [33:0] trial;
  logic [64:0] step;
  logic [31:0] quo, rem;
  logic [63:0] fin;

  assign accept = bus.start_i & ~bus.annul_i;
  assign abort  = bus.annul_i | ~bus.start_i;

  assign sgn1 = bus.signed_div_i & bus.opdata1_i[31];
  assign sgn2 = bus.signed_div_i & bus.opdata2_i[31];
  assign mag1 = sgn1 ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2 = sgn2 ? -bus.opdata2_i : bus.opdata2_i;

  // bit 64 of the shift register is always 0 between iterations
  assign trial = dvd_q[64:31] - {2'b0, dvs_q};
  assign step  = trial[33] ? {dvd_q[63:0], 1'b0}
                           : {trial[32:0], dvd_q[30:0], 1'b1};

  assign quo = step[31:0];
  assign rem = step[63:32];
  assign fin = {negr_q ? -rem : rem, negq_q ? -quo : quo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FREE;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      negq_q       <= negq_d;
      negr_q       <= negr_d;
      bus.result_o <= res_d;
      bus.ready_o  <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (accept) begin
`ifdef ITER_DIV_ZERO_CHECK_EN
          state_d = (bus.opdata2_i == '0) ? BYZERO : ON;
`else
          state_d = ON;
`endif
        end
      end
`ifdef ITER_DIV_ZERO_CHECK_EN
      BYZERO: state_d = abort ? FREE : END;
`endif
      ON: begin
        if (abort)
          state_d = FREE;
        else if (cnt_q == 6'd31)
          state_d = END;
      end
      END: begin
        if (abort)
          state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    res_d  = bus.result_o;
    rdy_d  = bus.ready_o;
    case (state_q)
      FREE: begin
        if (accept) begin
          cnt_d  = '0;
          dvd_d  = {33'b0, mag1};
          dvs_d  = mag2;
          negq_d = sgn1 ^ sgn2;
          negr_d = sgn1;
          res_d  = '0;
          rdy_d  = 1'b0;
        end
      end
`ifdef ITER_DIV_ZERO_CHECK_EN
      BYZERO: begin
        res_d = '0;
        rdy_d = ~abort;
      end
`endif
      ON: begin
        if (abort) begin
          res_d = '0;
          rdy_d = 1'b0;
        end else begin
          dvd_d = step;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            res_d = fin;
            rdy_d = 1'b1;
          end
        end
      end
      END: begin
        if (abort) begin
          res_d = '0;
          rdy_d = 1'b0;
        end
      end
      default: begin
        res_d = '0;
        rdy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: cycle model plus directed vectors.
// Honours ITER_DIV_ZERO_CHECK_EN the same way as the design.
module tb_iter_div;

  logic clk = 1'b0;
  logic rst = 1'b0;

  iter_div_if bus ();

  iter_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check64(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: truncating division, remainder takes dividend sign.
  function automatic logic [63:0] model_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
`ifdef ITER_DIV_ZERO_CHECK_EN
      return 64'd0;
`else
      if (!s)
        return {a, 32'hFFFF_FFFF};
      return {a, a[31] ? 32'd1 : 32'hFFFF_FFFF};
`endif
    end
    if (!s) begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int model_edges(input logic [31:0] b);
`ifdef ITER_DIV_ZERO_CHECK_EN
    if (b == 32'd0)
      return 1;
`endif
    return 32;
  endfunction

  // Cycle-level expectation of the outputs
  logic        m_rdy;
  logic        m_busy;
  logic [63:0] m_res;
  logic [63:0] m_pend;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rdy  <= 1'b0;
      m_busy <= 1'b0;
      m_res  <= '0;
      m_left <= 0;
    end else if (m_rdy) begin
      if (bus.annul_i || !bus.start_i) begin
        m_rdy <= 1'b0;
        m_res <= '0;
      end
    end else if (m_busy) begin
      if (bus.annul_i || !bus.start_i)
        m_busy <= 1'b0;
      else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_rdy  <= 1'b1;
        m_res  <= m_pend;
      end else
        m_left <= m_left - 1;
    end else if (bus.start_i && !bus.annul_i) begin
      m_busy <= 1'b1;
      m_left <= model_edges(bus.opdata2_i);
      m_pend <= model_div(bus.opdata1_i, bus.opdata2_i,
                          bus.signed_div_i);
    end
  end

  always @(negedge clk) begin
    check64("ready_vs_model", {63'b0, bus.ready_o}, {63'b0, m_rdy});
    check64("result_vs_model", bus.result_o, m_res);
  end

  task automatic start_and_wait(input logic [31:0] a,
                                input logic [31:0] b,
                                input logic s,
                                input logic [63:0] exp,
                                input int lat);
    int n;
    logic ok;
    @(negedge clk);
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = s;
    bus.start_i      = 1'b1;
    @(posedge clk);
    n  = 1;
    ok = 1'b0;
    #1;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~s;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok)
      n = 999;
    check64("latency", 64'(n), 64'(lat));
    check64("result_literal", bus.result_o, exp);
  endtask

  task automatic release_start();
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check64("ready_after_drop", {63'b0, bus.ready_o}, 64'd0);
    check64("result_after_drop", bus.result_o, 64'd0);
  endtask

  task automatic run(input logic [31:0] a,
                     input logic [31:0] b,
                     input logic s,
                     input logic [63:0] exp,
                     input int lat,
                     input int hold);
    start_and_wait(a, b, s, exp, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check64("hold_ready", {63'b0, bus.ready_o}, 64'd1);
      check64("hold_result", bus.result_o, exp);
    end
    release_start();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1 rst = 1'b1;
    #2;
    check64("reset_ready", {63'b0, bus.ready_o}, 64'd0);
    check64("reset_result", bus.result_o, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);
    run(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run(32'h80000000, 32'hFFFFFFFF, 1'b1,
        64'h00000000_80000000, 33, 0);
`ifdef ITER_DIV_ZERO_CHECK_EN
    run(32'd5, 32'd0, 1'b0, 64'd0, 2, 0);
`else
    run(32'd5, 32'd0, 1'b0, 64'h00000005_FFFFFFFF, 33, 0);
`endif
    run(32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 0);
    run(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1,
        64'hFFFFFFFE_0000000E, 33, 0);
    run(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 33, 0);
    run(32'd3, 32'd5, 1'b0, 64'h00000003_00000000, 33, 0);
    run(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 33, 4);

    // annul during iteration 10
    @(negedge clk);
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'd3;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    repeat (40) @(negedge clk);
    check64("annul_no_ready", {63'b0, bus.ready_o}, 64'd0);
    run(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 0);

    // async reset mid-iteration
    @(negedge clk);
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.signed_div_i = 1'b0;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check64("rst_on_ready", {63'b0, bus.ready_o}, 64'd0);
    check64("rst_on_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 0);

    // async reset while a result is held
    start_and_wait(32'd20, 32'd3, 1'b0, 64'h00000002_00000006, 33);
    #2 rst = 1'b1;
    #1;
    check64("rst_end_ready", {63'b0, bus.ready_o}, 64'd0);
    check64("rst_end_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(32'd21, 32'd4, 1'b0, 64'h00000001_00000005, 33, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
